// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer for a variable-latency data memory
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] rdata_out,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_COMPLETE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             access;
    logic             illegal;
    logic             start;
    logic             cnt_inc;
    logic             rd_capture;

    assign access  = valid_in & (mem_read_in | mem_write_in);
    assign illegal = addr_in[0] | (mem_read_in & mem_write_in);

    // Request and fault flags decode straight from state so reset clears them at once.
    assign mem_req = (state == S_ACCESS);
    assign err     = (state == S_ERR);

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        wb_valid   = 1'b0;
        start      = 1'b0;
        cnt_inc    = 1'b0;
        rd_capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (illegal) begin
                        state_nxt = S_ERR;
                    end else begin
                        start     = 1'b1;
                        state_nxt = S_ACCESS;
                    end
                end else begin
                    wb_valid = valid_in;
                end
            end
            S_ACCESS: begin
                stall = 1'b1;
                if (mem_done) begin
                    rd_capture = ~mem_wr;
                    state_nxt  = S_COMPLETE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ERR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_COMPLETE: begin
                wb_valid  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                stall = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_out <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                mem_addr  <= addr_in;
                mem_wdata <= wdata_in;
                mem_wr    <= mem_write_in;
                cnt       <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (rd_capture) begin
                rdata_out <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the 16-bit pipeline. It runs each load or store as a multi-cycle handshake with a variable-latency data memory. While the access is outstanding it stalls the pipeline. On completion it delivers the load data and a write-back valid to the MEM/WB pipeline register. Alignment errors, illegal access requests and memory timeouts become a sticky error that freezes the pipeline.

## Interface
- TIMEOUT, 15: maximum number of cycles `mem_req` is held for one access; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the timeout counter.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- valid_in  in  1  MEM stage holds a real instruction (0 = bubble).
- mem_read_in  in  1  MEM-stage instruction is a load.
- mem_write_in  in  1  MEM-stage instruction is a store.
- addr_in  in  16  byte address (ALU result).
- wdata_in  in  16  store data.
- mem_req  out  1  access request to data memory; held high until `mem_done`.
- mem_wr  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- mem_addr  out  16  latched address.
- mem_wdata  out  16  latched store data.
- mem_done  in  1  memory completes the access this cycle.
- mem_rdata  in  16  read data; valid when `mem_done` is high.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers.
- wb_valid  out  1  MEM/WB captures a real instruction; 0 forces the captured `reg_write` to 0.
- rdata_out  out  16  load data to the MEM/WB `data_mem` input.
- err  out  1  sticky fault flag.

## Operation
- States: IDLE, ACCESS, COMPLETE, ERR. Encoding is free.
- An access is `valid_in & (mem_read_in | mem_write_in)`.
- IDLE, no access:
  - `stall`=0.
  - `wb_valid`=`valid_in`.
  - `mem_req`=0.
  - Stay in IDLE.
- IDLE, access with `addr_in[0]`=1, or with `mem_read_in & mem_write_in`:
  - Go to ERR.
  - `stall`=1 combinationally.
  - No request is issued.
- IDLE, legal access:
  - `stall`=1 and `wb_valid`=0 combinationally.
  - Latch `addr_in`, `wdata_in` and `mem_write_in` into `mem_addr`, `mem_wdata` and `mem_wr`.
  - Clear the counter.
  - Go to ACCESS.
- ACCESS:
  - `mem_req`=1, `stall`=1, `wb_valid`=0.
  - Latched address, data and write flag stay stable.
  - On `mem_done`: if a read, latch `mem_rdata` into `rdata_out`; go to COMPLETE.
  - Otherwise, if counter == TIMEOUT-1, go to ERR.
  - Otherwise, increment the counter.
- COMPLETE:
  - `mem_req`=0, `stall`=0, `wb_valid`=1.
  - The pipeline advances at the end of this cycle.
  - Always go to IDLE.
  - Inputs are ignored in this state. The next instruction is evaluated in IDLE one cycle later.
- ERR:
  - `stall`=1, `wb_valid`=0, `mem_req`=0, `err`=1.
  - Only reset leaves ERR.
- `mem_done` is ignored in IDLE, COMPLETE and ERR.
- `rdata_out` changes only on read completion; stores and non-memory instructions leave it unchanged.

## Timing
- Reset values: state IDLE; counter, `mem_req`, `mem_wr`, `mem_addr`, `mem_wdata`, `rdata_out` and `err` all 0.
- `stall` and `wb_valid` are combinational from state and inputs. With `valid_in`=0 in IDLE after reset, `stall`=0 and `wb_valid`=0.
- Reset asserted mid-access: outputs go to reset values immediately and `mem_req` drops with no completion.
- Access seen in IDLE at cycle N:
  - `mem_req` is high from N+1.
  - With `mem_done` at N+k (k≥1), COMPLETE is at N+k+1.
  - `stall` is high for cycles N..N+k.
  - Minimum total occupancy is 3 cycles.
- At most TIMEOUT cycles of `mem_req`. If `mem_done` never arrives, `err` rises at N+TIMEOUT+1.
- `mem_done` arriving in the same cycle the counter reaches TIMEOUT-1: done wins, normal completion.
- Back-to-back memory instructions: one IDLE cycle separates them. The second instruction's `mem_req` rises 2 cycles after the first COMPLETE cycle.

## Test plan
- Load `addr_in`=0x0010, memory returns 0xBEEF with `mem_done` 1 cycle after `mem_req` rises → `mem_req` high for 1 cycle, `mem_addr`=0x0010, `mem_wr`=0, `stall` high 2 cycles, COMPLETE with `wb_valid`=1 and `rdata_out`=0xBEEF.
- Store 0x1234 to 0x0020, `mem_done` after 4 cycles → `mem_wr`=1, `mem_wdata`=0x1234 stable for all 4 cycles, `rdata_out` unchanged, `stall` high 5 cycles.
- Load with `addr_in`=0x0021 → no `mem_req`, `err`=1 next cycle, `stall` stays 1 until reset; same result for `mem_read_in`=`mem_write_in`=1.
- TIMEOUT=15, `mem_done` held 0 → `mem_req` high exactly 15 cycles, then `err`=1. Repeat with `mem_done` on the 15th cycle → normal COMPLETE, `err`=0.
- Non-memory instructions with `valid_in`=1, then bubbles with `valid_in`=0 → `stall`=0 throughout, `wb_valid` follows `valid_in`, `mem_req` never asserted.
- Assert `rst`=0 mid-ACCESS → `mem_req` and `stall` drop immediately; after release, a new load completes normally.
